// File: rtl/pretu_2d_seq.sv
// 4x4 tile pre-transform, sequential form.
// Rows stream in one beat per cycle and get the row pass on the way into the
// buffer. The column pass is then applied to one buffer column per output beat.
// T(a,b,c,d) = (a-c, b+c, -b+c, b-d); every stage widens by one bit, so the
// arithmetic is exact with no saturation.

// One T butterfly; the output is one bit wider than the input.
module pretu_2d_seq_t #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W:0]   p,
  output logic signed [W:0]   q,
  output logic signed [W:0]   r,
  output logic signed [W:0]   s
);
  logic signed [W:0] ae, be, ce, de;

  assign ae = {a[W-1], a};
  assign be = {b[W-1], b};
  assign ce = {c[W-1], c};
  assign de = {d[W-1], d};

  assign p = ae - ce;
  assign q = be + ce;
  assign r = ce - be;
  assign s = be - de;
endmodule

module pretu_2d_seq #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_x0,
  input  logic signed [DW-1:0] in_x1,
  input  logic signed [DW-1:0] in_x2,
  input  logic signed [DW-1:0] in_x3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW+1:0] out_y0,
  output logic signed [DW+1:0] out_y1,
  output logic signed [DW+1:0] out_y2,
  output logic signed [DW+1:0] out_y3,
  output logic [1:0]           out_col,
  output logic                 out_last,
  output logic                 busy
);
  localparam logic ST_LOAD  = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  logic                  st;
  logic [1:0]            row_cnt;
  logic [1:0]            col_cnt;
  logic                  tile_mode;
  logic [3:0][3:0][DW:0] tbuf;      // tbuf[row][col], row-pass results
  logic signed [DW:0]    rp [4];    // row pass of the incoming beat
  logic signed [DW:0]    cs [4];    // buffer column being drained
  logic signed [DW+1:0]  cp [4];    // column pass of that column
  logic                  accept;
  logic                  ohs;

  assign in_ready  = (st == ST_LOAD);
  assign out_valid = (st == ST_DRAIN);
  assign accept    = in_valid & in_ready;
  assign ohs       = out_valid & out_ready;
  assign out_col   = col_cnt;
  assign out_last  = out_valid & (col_cnt == 2'd3);
  assign busy      = (st != ST_LOAD) | (row_cnt != 2'd0);

  pretu_2d_seq_t #(.W(DW)) u_row (
    .a(in_x0), .b(in_x1), .c(in_x2), .d(in_x3),
    .p(rp[0]), .q(rp[1]), .r(rp[2]), .s(rp[3])
  );

  // Pick the current drain column out of the buffer, top row first.
  always_comb begin
    for (int k = 0; k < 4; k++) cs[k] = $signed(tbuf[k][col_cnt]);
  end

  pretu_2d_seq_t #(.W(DW + 1)) u_col (
    .a(cs[0]), .b(cs[1]), .c(cs[2]), .d(cs[3]),
    .p(cp[0]), .q(cp[1]), .r(cp[2]), .s(cp[3])
  );

  // tile_mode 0 drives zero data; the handshake runs as normal.
  assign out_y0 = tile_mode ? cp[0] : '0;
  assign out_y1 = tile_mode ? cp[1] : '0;
  assign out_y2 = tile_mode ? cp[2] : '0;
  assign out_y3 = tile_mode ? cp[3] : '0;

  // Row and column sequencing: 4 accepted rows, then 4 accepted columns.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= ST_LOAD;
      row_cnt   <= 2'd0;
      col_cnt   <= 2'd0;
      tile_mode <= 1'b0;
    end else begin
      case (st)
        ST_LOAD: if (accept) begin
          if (row_cnt == 2'd0) tile_mode <= mode;
          row_cnt <= row_cnt + 2'd1;
          if (row_cnt == 2'd3) begin
            st      <= ST_DRAIN;
            col_cnt <= 2'd0;
          end
        end
        ST_DRAIN: if (ohs) begin
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) begin
            st      <= ST_LOAD;
            row_cnt <= 2'd0;
          end
        end
        default: st <= ST_LOAD;
      endcase
    end
  end

  // Row-pass results land in the buffer row picked by the row count; no reset.
  always_ff @(posedge clk) begin
    if (accept) tbuf[row_cnt] <= {rp[3], rp[2], rp[1], rp[0]};
  end
endmodule

// File: tb/tb_pretu_2d_seq.sv
// Directed bench for pretu_2d_seq. Inputs are driven and outputs sampled on
// the falling edge; the DUT acts on the rising edge in between.
module tb_pretu_2d_seq;
  localparam int DW = 16;
  typedef logic signed [DW+1:0] yv_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 mode = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_x0 = '0, in_x1 = '0, in_x2 = '0, in_x3 = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW+1:0] out_y0, out_y1, out_y2, out_y3;
  logic [1:0]           out_col;
  logic                 out_last;
  logic                 busy;

  pretu_2d_seq #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y0(out_y0), .out_y1(out_y1), .out_y2(out_y2), .out_y3(out_y3),
    .out_col(out_col), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int  nvec = 0;
  int  nerr = 0;
  int  tile  [4][4];   // tile[row][k] input elements
  int  exp_y [4][4];   // exp_y[col][k] expected outputs
  yv_t got   [4][4];   // got[col][k] captured outputs
  int  nhs, bad_order, bad_stable, bad_inrdy, bad_last, first_valid;

  // Present the four rows of tile[], one per cycle; mode m0 on row 0, mr after.
  task automatic send_tile(input logic m0, input logic mr);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      mode = (r == 0) ? m0 : mr;
      in_valid = 1'b1;
      in_x0 = DW'(tile[r][0]); in_x1 = DW'(tile[r][1]);
      in_x2 = DW'(tile[r][2]); in_x3 = DW'(tile[r][3]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    mode = 1'b0;
  endtask

  // Collect one drained tile into got[], counting protocol anomalies.
  task automatic drain(input bit stall);
    int  run;
    bit  stalled, done;
    yv_t prev [5];
    run = 0; stalled = 0; done = 0;
    nhs = 0; bad_order = 0; bad_stable = 0; bad_inrdy = 0; bad_last = 0;
    first_valid = -1;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (in_ready !== 1'b0) bad_inrdy++;
        if (out_last !== (out_col == 2'd3)) bad_last++;
        if (stalled && (out_y0 !== prev[0] || out_y1 !== prev[1] ||
                        out_y2 !== prev[2] || out_y3 !== prev[3] ||
                        yv_t'(out_col) !== prev[4])) bad_stable++;
        out_ready = (!stall || run >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        run = out_ready ? 0 : run + 1;
        prev[0] = out_y0; prev[1] = out_y1; prev[2] = out_y2; prev[3] = out_y3;
        prev[4] = yv_t'(out_col);
        stalled = !out_ready;
        if (out_ready) begin
          if (int'(out_col) != nhs) bad_order++;
          if (nhs < 4) begin
            got[nhs][0] = out_y0; got[nhs][1] = out_y1;
            got[nhs][2] = out_y2; got[nhs][3] = out_y3;
          end
          nhs++;
          if (out_col == 2'd3) done = 1;
        end
      end else begin
        if (out_last !== 1'b0) bad_last++;
        stalled = 0;
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic set_tile_1234();
    for (int r = 0; r < 4; r++) tile[r] = '{1, 2, 3, 4};
    exp_y = '{'{0, -4, 0, 0}, '{0, 10, 0, 0}, '{0, 2, 0, 0}, '{0, -4, 0, 0}};
  endtask

  task automatic set_tile_ident();
    tile  = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 0, 1}};
    exp_y = '{'{2, -1, -1, 0}, '{-1, 2, 0, 1}, '{-1, 0, 2, -1}, '{0, 1, -1, 2}};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    nvec++; if (out_last !== 1'b0) begin nerr++; $display("FAIL rst_out_last got=%b want=0", out_last); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got=%b want=0", busy); end
    nvec++; if (out_col !== 2'd0) begin nerr++; $display("FAIL rst_out_col got=%0d want=0", out_col); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    nvec++; if (in_ready !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL post_rst in_ready/busy got=%b/%b want=1/0", in_ready, busy); end
    // One accepted row must raise busy.
    in_valid = 1'b1; mode = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL busy_after_row got=%b want=1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL busy_after_rst got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    set_tile_1234();
    send_tile(1'b1, 1'b1);
    drain(1'b0);
    nvec++; if (first_valid !== 0) begin nerr++; $display("FAIL basic_latency got=%0d want=0", first_valid); end
    nvec++; if (nhs !== 4 || bad_order !== 0) begin nerr++; $display("FAIL basic_cols got=%0d/%0d want=4/0", nhs, bad_order); end
    nvec++; if (bad_last !== 0 || bad_inrdy !== 0) begin nerr++; $display("FAIL basic_last_inrdy got=%0d/%0d want=0/0", bad_last, bad_inrdy); end
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (got[c][k] !== yv_t'(exp_y[c][k])) begin
          nerr++; $display("FAIL basic_y col%0d y%0d got=%0d want=%0d", c, k, got[c][k], exp_y[c][k]);
        end
      end
  endtask

  task automatic test_mode_latch();
    set_tile_1234();
    send_tile(1'b1, 1'b0);
    drain(1'b0);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (got[c][k] !== yv_t'(exp_y[c][k])) begin
          nerr++; $display("FAIL mode1_y col%0d y%0d got=%0d want=%0d", c, k, got[c][k], exp_y[c][k]);
        end
      end
    send_tile(1'b0, 1'b1);
    drain(1'b0);
    nvec++; if (nhs !== 4 || bad_order !== 0 || bad_last !== 0) begin nerr++; $display("FAIL mode0_hs got=%0d/%0d/%0d want=4/0/0", nhs, bad_order, bad_last); end
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (got[c][k] !== yv_t'(0)) begin
          nerr++; $display("FAIL mode0_y col%0d y%0d got=%0d want=0", c, k, got[c][k]);
        end
      end
  endtask

  task automatic test_stall();
    set_tile_ident();
    send_tile(1'b1, 1'b1);
    drain(1'b1);
    nvec++; if (nhs !== 4 || bad_order !== 0) begin nerr++; $display("FAIL stall_cols got=%0d/%0d want=4/0", nhs, bad_order); end
    nvec++; if (bad_stable !== 0) begin nerr++; $display("FAIL stall_stable got=%0d want=0", bad_stable); end
    nvec++; if (bad_inrdy !== 0 || bad_last !== 0) begin nerr++; $display("FAIL stall_inrdy_last got=%0d/%0d want=0/0", bad_inrdy, bad_last); end
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (got[c][k] !== yv_t'(exp_y[c][k])) begin
          nerr++; $display("FAIL stall_y col%0d y%0d got=%0d want=%0d", c, k, got[c][k], exp_y[c][k]);
        end
      end
  endtask

  task automatic test_extreme();
    for (int r = 0; r < 4; r++) tile[r] = '{32767, 0, -32768, 0};
    exp_y = '{'{0, 131070, 0, 0}, '{0, -65536, 0, 0}, '{0, -65536, 0, 0}, '{0, 0, 0, 0}};
    send_tile(1'b1, 1'b1);
    drain(1'b0);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (got[c][k] !== yv_t'(exp_y[c][k])) begin
          nerr++; $display("FAIL extreme_y col%0d y%0d got=%0d want=%0d", c, k, got[c][k], exp_y[c][k]);
        end
      end
  endtask

  task automatic test_reset_mid();
    // Two junk rows, then reset; the following tile must stand alone.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      in_valid = 1'b1; mode = 1'b1;
      in_x0 = 16'sd100; in_x1 = -16'sd7; in_x2 = 16'sd55; in_x3 = 16'sd9;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_tile_ident();
    send_tile(1'b1, 1'b1);
    drain(1'b0);
    nvec++; if (first_valid !== 0 || nhs !== 4) begin nerr++; $display("FAIL rstload_hs got=%0d/%0d want=0/4", first_valid, nhs); end
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (got[c][k] !== yv_t'(exp_y[c][k])) begin
          nerr++; $display("FAIL rstload_y col%0d y%0d got=%0d want=%0d", c, k, got[c][k], exp_y[c][k]);
        end
      end
    // Reset in the middle of a drain.
    send_tile(1'b1, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nerr++; $display("FAIL rstdrain vld/rdy got=%b/%b want=0/1", out_valid, in_ready); end
    nvec++; if (out_col !== 2'd0 || busy !== 1'b0 || out_last !== 1'b0) begin nerr++; $display("FAIL rstdrain col/busy/last got=%0d/%b/%b want=0/0/0", out_col, busy, out_last); end
    set_tile_1234();
    send_tile(1'b1, 1'b1);
    drain(1'b0);
    nvec++; if (got[1][1] !== yv_t'(10) || nhs !== 4) begin nerr++; $display("FAIL rstdrain_next got=%0d/%0d want=10/4", got[1][1], nhs); end
  endtask

  task automatic test_back_to_back();
    int  t0 [4][4], t1 [4][4], e0 [4][4], e1 [4][4];
    yv_t g [2][4][4];
    int  ri, tix, ncol, last_cyc [2], bad;
    set_tile_1234(); t0 = tile; e0 = exp_y;
    set_tile_ident(); t1 = tile; e1 = exp_y;
    ri = 0; tix = 0; ncol = 0; bad = 0; last_cyc = '{-1, -1};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && tix < 2; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (int'(out_col) != ncol) bad++;
        if (in_ready !== 1'b0) bad++;
        g[tix][out_col][0] = out_y0; g[tix][out_col][1] = out_y1;
        g[tix][out_col][2] = out_y2; g[tix][out_col][3] = out_y3;
        ncol++;
        if (out_last) begin last_cyc[tix] = cyc; tix++; ncol = 0; end
      end
      if (in_ready && ri < 8) begin
        in_valid = 1'b1; mode = 1'b1;
        if (ri < 4) begin
          in_x0 = DW'(t0[ri][0]); in_x1 = DW'(t0[ri][1]); in_x2 = DW'(t0[ri][2]); in_x3 = DW'(t0[ri][3]);
        end else begin
          in_x0 = DW'(t1[ri-4][0]); in_x1 = DW'(t1[ri-4][1]); in_x2 = DW'(t1[ri-4][2]); in_x3 = DW'(t1[ri-4][3]);
        end
        ri++;
      end else if (ri >= 8) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    nvec++; if (last_cyc[0] !== 7 || last_cyc[1] !== 15) begin nerr++; $display("FAIL b2b_period got=%0d/%0d want=7/15", last_cyc[0], last_cyc[1]); end
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL b2b_order got=%0d want=0", bad); end
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (g[0][c][k] !== yv_t'(e0[c][k]) || g[1][c][k] !== yv_t'(e1[c][k])) begin
          nerr++; $display("FAIL b2b_y col%0d y%0d got=%0d/%0d want=%0d/%0d", c, k, g[0][c][k], g[1][c][k], e0[c][k], e1[c][k]);
        end
      end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mode_latch();
    test_stall();
    test_extreme();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
